// File: rtl/autoseller_pkg.sv
// rtl/autoseller_pkg.sv - shared types and constants for the autoseller_multi vending controller
//
// Contents:
//   state_t        controller state (OFF, COLLECT, VEND, CHANGE)
//   COIN_LO/HI     coin values in half-yuan units
//   SEG_DIGITS     active-low 7-segment patterns for 0-9, bit order gfedcba, digit 0 at the LSBs
//   SEG_BLANK      all segments off
//   SEG_DASH       only segment g lit
//   pow10()        elaboration-time power of ten for the display range
package autoseller_pkg;

   typedef enum logic [1:0] {
      OFF,
      COLLECT,
      VEND,
      CHANGE
   } state_t;

   localparam logic [1:0] COIN_LO = 2'd1;
   localparam logic [1:0] COIN_HI = 2'd2;

   localparam logic [9:0][6:0] SEG_DIGITS = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - 4-bit BCD to active-low 7-segment decoder
//
// Ports:
//   bcd  in   4  BCD digit; codes above 9 decode to blank
//   seg  out  7  active-low segments, gfedcba
module seg7_dec
   import autoseller_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (bcd <= 4'd9) seg = SEG_DIGITS[bcd];
   end

endmodule

// File: rtl/autoseller_multi.sv
// rtl/autoseller_multi.sv - multi-product vending controller with credit, vend and change payout
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               level, machine in service
//   cancel              active-low, falling edge requests a refund
//   Key_in[1:0]         active-low coin keys (bit0 = 1 unit, bit1 = 2 units)
//   sel, buy            product select and 1-cycle purchase pulse
//   chg_rdy/chg_vld     change coin handshake, chg_coin 1 = 2-unit coin
//   hold_ind, charge_ind, drinktk_ind, drink_id   status and vend outputs
//   coin_val, coin_rej  last accepted coin, 1-cycle reject pulse
//   credit, charge_val  credit held and change still owed
//   HEX                 active-low 7-segment digits, digit 0 at the LSBs
// Build option: AUTOSELLER_TIMEOUT_EN adds an inactivity refund after TIMEOUT_CYC idle cycles.
module autoseller_multi
   import autoseller_pkg::*;
#(
   parameter int                      N_PROD      = 4,
   parameter int                      PRICE_W     = 6,
   parameter logic [N_PROD*PRICE_W-1:0] PRICE_TABLE = {6'd5, 6'd4, 6'd3, 6'd2},
   parameter int                      CREDIT_MAX  = 40,
   parameter int                      N_DIGITS    = 2,
   parameter int                      TIMEOUT_CYC = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      cancel,
   input  logic [1:0]                Key_in,
   input  logic [$clog2(N_PROD)-1:0] sel,
   input  logic                      buy,
   input  logic                      chg_rdy,
   output logic                      chg_vld,
   output logic                      chg_coin,
   output logic                      hold_ind,
   output logic                      charge_ind,
   output logic                      drinktk_ind,
   output logic [$clog2(N_PROD)-1:0] drink_id,
   output logic [1:0]                coin_val,
   output logic                      coin_rej,
   output logic [PRICE_W-1:0]        credit,
   output logic [PRICE_W-1:0]        charge_val,
   output logic [7*N_DIGITS-1:0]     HEX
);

   localparam int                 SEL_W    = $clog2(N_PROD);
   localparam logic [SEL_W:0]     N_PROD_L = (SEL_W+1)'(N_PROD);
   localparam logic [PRICE_W:0]   CMAX     = (PRICE_W+1)'(CREDIT_MAX);
   localparam int                 DISP_MAX = pow10(N_DIGITS) - 1;

   state_t              state, state_n;
   logic [1:0]          key_d1, key_d2, key_fall;
   logic                cancel_d1, cancel_d2, cancel_ev;
   logic                timeout, abort, sel_ok;
   logic [PRICE_W-1:0]  price_sel, credit_n, charge_n;
   logic [SEL_W-1:0]    drink_id_n;
   logic [1:0]          coin_val_n, coin_add;
   logic                coin_rej_n;
   logic [PRICE_W:0]    sum;

   // Two register stages so a key edge is acted on in the cycle after it is captured.
   assign key_fall  = key_d2 & ~key_d1;
   assign cancel_ev = cancel_d2 & ~cancel_d1;
   assign abort     = cancel_ev | ~start | timeout;
   assign sel_ok    = {1'b0, sel} < N_PROD_L;

   always_comb begin
      price_sel = '0;
      for (int i = 0; i < N_PROD; i++)
         if (SEL_W'(i) == sel) price_sel = PRICE_TABLE[i*PRICE_W +: PRICE_W];
   end

`ifdef AUTOSELLER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] idle_cnt;
   logic            any_event;

   assign any_event = (|key_fall) | buy | cancel_ev;
   assign timeout   = (state == COLLECT) && (idle_cnt == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (rst || state != COLLECT || credit == '0 || any_event)
         idle_cnt <= '0;
      else if (!timeout)
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   // The timeout length only drives logic when the feature is built in.
   logic timeout_unused;
   assign timeout_unused = (TIMEOUT_CYC > 0);
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= OFF;
         key_d1     <= 2'b11;
         key_d2     <= 2'b11;
         cancel_d1  <= 1'b1;
         cancel_d2  <= 1'b1;
         credit     <= '0;
         charge_val <= '0;
         drink_id   <= '0;
         coin_val   <= '0;
         coin_rej   <= 1'b0;
      end else begin
         state      <= state_n;
         key_d1     <= Key_in;
         key_d2     <= key_d1;
         cancel_d1  <= cancel;
         cancel_d2  <= cancel_d1;
         credit     <= credit_n;
         charge_val <= charge_n;
         drink_id   <= drink_id_n;
         coin_val   <= coin_val_n;
         coin_rej   <= coin_rej_n;
      end
   end

   always_comb begin
      state_n    = state;
      credit_n   = credit;
      charge_n   = charge_val;
      drink_id_n = drink_id;
      coin_val_n = coin_val;
      coin_rej_n = 1'b0;
      coin_add   = COIN_LO;
      sum        = '0;
      case (state)
         OFF: if (start) state_n = COLLECT;
         COLLECT: begin
            if (abort) begin
               if (credit == '0) begin
                  state_n = start ? COLLECT : OFF;
               end else begin
                  charge_n = credit;
                  credit_n = '0;
                  state_n  = CHANGE;
               end
            end else if (buy) begin
               if (sel_ok && credit >= price_sel) begin
                  drink_id_n = sel;
                  charge_n   = credit - price_sel;
                  credit_n   = '0;
                  state_n    = VEND;
               end else begin
                  coin_rej_n = 1'b1;
               end
            end else if (key_fall == 2'b11) begin
               coin_rej_n = 1'b1;
            end else if (key_fall != 2'b00) begin
               coin_add = key_fall[0] ? COIN_LO : COIN_HI;
               sum      = {1'b0, credit} + (PRICE_W+1)'(coin_add);
               if (sum <= CMAX) begin
                  credit_n   = sum[PRICE_W-1:0];
                  coin_val_n = key_fall;
               end else begin
                  coin_rej_n = 1'b1;
               end
            end
         end
         VEND: state_n = CHANGE;
         CHANGE: begin
            if (charge_val == '0)
               state_n = start ? COLLECT : OFF;
            else if (chg_rdy)
               charge_n = charge_val - PRICE_W'(chg_coin ? COIN_HI : COIN_LO);
         end
         default: state_n = OFF;
      endcase
   end

   assign hold_ind    = (state == COLLECT);
   assign charge_ind  = (state == CHANGE);
   assign drinktk_ind = (state == VEND);
   assign chg_vld     = (state == CHANGE) && (charge_val != '0);
   assign chg_coin    = |charge_val[PRICE_W-1:1];

   // Display: credit while collecting, change owed while vending/paying.
   logic [PRICE_W-1:0]         disp_val, tmp;
   logic [N_DIGITS-1:0][3:0]   bcd;
   logic [6:0]                 seg_raw [N_DIGITS];
   logic                       over;

   assign disp_val = (state == VEND || state == CHANGE) ? charge_val : credit;
   assign over     = 32'(disp_val) > DISP_MAX;

   always_comb begin
      tmp = disp_val;
      bcd = '0;
      for (int d = 0; d < N_DIGITS; d++) begin
         bcd[d] = 4'(tmp % PRICE_W'(10));
         tmp    = tmp / PRICE_W'(10);
      end
   end

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
      seg7_dec u_dec (
         .bcd (bcd[g]),
         .seg (seg_raw[g])
      );
   end

   always_comb begin
      HEX = '1;
      for (int d = 0; d < N_DIGITS; d++)
         HEX[d*7 +: 7] = (state == OFF) ? SEG_BLANK : (over ? SEG_DASH : seg_raw[d]);
   end

endmodule

// File: tb/tb_autoseller_multi.sv
// tb/tb_autoseller_multi.sv - directed self-checking bench for autoseller_multi
module tb_autoseller_multi;

`ifdef AUTOSELLER_TIMEOUT_EN
   localparam int TB_TO = 10;
`else
   localparam int TB_TO = 1000;
`endif

   logic        clk = 1'b0;
   logic        rst, start, cancel, buy, chg_rdy;
   logic [1:0]  Key_in, sel;
   logic        chg_vld, chg_coin, hold_ind, charge_ind, drinktk_ind, coin_rej;
   logic [1:0]  drink_id, coin_val;
   logic [5:0]  credit, charge_val;
   logic [13:0] HEX;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   autoseller_multi #(
      .N_PROD      (4),
      .PRICE_W     (6),
      .PRICE_TABLE ({6'd5, 6'd4, 6'd3, 6'd2}),
      .CREDIT_MAX  (40),
      .N_DIGITS    (2),
      .TIMEOUT_CYC (TB_TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cancel      (cancel),
      .Key_in      (Key_in),
      .sel         (sel),
      .buy         (buy),
      .chg_rdy     (chg_rdy),
      .chg_vld     (chg_vld),
      .chg_coin    (chg_coin),
      .hold_ind    (hold_ind),
      .charge_ind  (charge_ind),
      .drinktk_ind (drinktk_ind),
      .drink_id    (drink_id),
      .coin_val    (coin_val),
      .coin_rej    (coin_rej),
      .credit      (credit),
      .charge_val  (charge_val),
      .HEX         (HEX)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Active-low gfedcba patterns, typed in from the usual common-anode table.
   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  default: return 7'h10;
      endcase
   endfunction

   function automatic logic [13:0] hex2(input int d1, input int d0);
      return {seg(d1), seg(d0)};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   // Press the keys in mask (1 = pressed) and report coin_rej from the cycle the coin is handled.
   task automatic press(input logic [1:0] mask, output logic rej);
      Key_in = ~mask;
      tick();
      tick();
      rej = coin_rej;
      Key_in = 2'b11;
      tick();
      tick();
      tick();
   endtask

   logic rej;
   int   paid;
   int   all_hi;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; cancel = 1'b1; buy = 1'b0; chg_rdy = 1'b0;
      Key_in = 2'b11; sel = 2'd0;
      tick(); tick(); tick();
      check("rst_hold", hold_ind, 0);
      check("rst_charge_ind", charge_ind, 0);
      check("rst_credit", credit, 0);
      check("rst_coin_val", coin_val, 0);
      check("rst_chg_vld", chg_vld, 0);
      check("rst_hex", HEX, 14'h3FFF);
      rst = 1'b0;
      tick();
      check("off_hold", hold_ind, 0);

      // service on, three 0.5 coins
      start = 1'b1;
      tick();
      check("collect_hold", hold_ind, 1);
      check("collect_hex00", HEX, hex2(0, 0));
      for (int i = 0; i < 3; i++) begin
         press(2'b01, rej);
         check("lo_coin_rej", rej, 0);
      end
      check("credit3", credit, 3);
      check("coin_val_lo", coin_val, 2'b01);
      check("hex03", HEX, hex2(0, 3));

      // buy product 0 (price 2), change of one 0.5 coin
      sel = 2'd0; buy = 1'b1;
      tick();
      buy = 1'b0;
      check("vend_pulse", drinktk_ind, 1);
      check("vend_id", drink_id, 0);
      check("vend_charge", charge_val, 1);
      check("vend_credit", credit, 0);
      tick();
      check("vend_once", drinktk_ind, 0);
      check("chg_state", charge_ind, 1);
      check("chg_vld1", chg_vld, 1);
      check("chg_coin_lo", chg_coin, 0);
      check("hex01", HEX, hex2(0, 1));
      chg_rdy = 1'b1;
      tick();
      chg_rdy = 1'b0;
      check("chg_paid", charge_val, 0);
      check("chg_vld_off", chg_vld, 0);
      tick();
      check("back_collect", hold_ind, 1);

      // two 1-yuan coins, cancel, stalled dispenser
      press(2'b10, rej);
      press(2'b10, rej);
      check("credit4", credit, 4);
      check("coin_val_hi", coin_val, 2'b10);
      cancel = 1'b0;
      tick();
      tick();
      cancel = 1'b1;
      check("cancel_change", charge_ind, 1);
      check("cancel_charge", charge_val, 4);
      check("cancel_credit", credit, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_stable", {chg_vld, chg_coin, charge_val}, {1'b1, 1'b1, 6'd4});
      end
      chg_rdy = 1'b1;
      tick();
      check("refund_first", {chg_vld, chg_coin, charge_val}, {1'b1, 1'b1, 6'd2});
      tick();
      chg_rdy = 1'b0;
      check("refund_done", charge_val, 0);
      tick();
      check("refund_collect", hold_ind, 1);
      check("refund_credit", credit, 0);

      // insufficient credit and simultaneous keys
      press(2'b10, rej);
      check("credit2", credit, 2);
      sel = 2'd3; buy = 1'b1;
      tick();
      buy = 1'b0;
      check("poor_buy_rej", coin_rej, 1);
      check("poor_buy_novend", drinktk_ind, 0);
      check("poor_buy_credit", credit, 2);
      tick();
      check("rej_pulse_end", coin_rej, 0);
      press(2'b11, rej);
      check("both_keys_rej", rej, 1);
      check("both_keys_credit", credit, 2);

      // fill to the ceiling and overflow
      for (int i = 0; i < 19; i++) press(2'b10, rej);
      check("credit40", credit, 40);
      check("hex40", HEX, hex2(4, 0));
      press(2'b01, rej);
      check("over_rej", rej, 1);
      check("over_credit", credit, 40);
      check("over_coin_val", coin_val, 2'b10);

      // service off with credit: refund everything, then OFF
      start = 1'b0;
      tick();
      check("off_refund_state", charge_ind, 1);
      check("off_refund_val", charge_val, 40);
      paid = 0;
      all_hi = 1;
      chg_rdy = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (!charge_ind && !hold_ind) break;
         if (chg_vld) begin
            paid++;
            if (!chg_coin) all_hi = 0;
         end
         tick();
      end
      chg_rdy = 1'b0;
      check("off_coins_paid", paid, 20);
      check("off_all_hi", all_hi, 1);
      check("off_final_state", {hold_ind, charge_ind}, 2'b00);
      check("off_hex_blank", HEX, 14'h3FFF);

`ifdef AUTOSELLER_TIMEOUT_EN
      start = 1'b1;
      tick();
      press(2'b01, rej);
      check("to_credit1", credit, 1);
      for (int i = 0; i < 40; i++) begin
         if (charge_ind) break;
         tick();
      end
      check("to_change", charge_ind, 1);
      check("to_charge", charge_val, 1);
      check("to_coin", {chg_vld, chg_coin}, 2'b10);
      chg_rdy = 1'b1;
      tick();
      chg_rdy = 1'b0;
      tick();
      check("to_back", hold_ind, 1);
      check("to_credit0", credit, 0);
`endif

      // reset in the middle of collecting loses credit
      start = 1'b1;
      tick();
      press(2'b10, rej);
      check("pre_rst_credit", credit, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_credit", credit, 0);
      check("mid_rst_hold", hold_ind, 0);
      check("mid_rst_coin_val", coin_val, 0);
      check("mid_rst_hex", HEX, 14'h3FFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/autoseller_multi.md
Name: autoseller_multi

Overview:
- Parametrised next-generation vending controller: N_PROD products with per-product prices, credit accumulation from two active-low coin keys, and purchase with the remaining balance paid out as change.
- Change is paid out one coin at a time over a valid/ready handshake to the coin dispenser.
- Balance is shown on N_DIGITS active-low 7-segment displays.
- Sits between board keys/switches and the dispenser/display I/O of the top level.

Parameters:
- N_PROD, 4, number of products (>=2).
- PRICE_W, 6, width of credit/price in half-yuan units.
- PRICE_TABLE, {6'd5,6'd4,6'd3,6'd2}, packed N_PROD*PRICE_W; product i price = slice i (LSB slice = product 0).
- CREDIT_MAX, 40, credit ceiling in half-units; coins that would exceed it are rejected.
- N_DIGITS, 2, number of decimal display digits.
- TIMEOUT_CYC, 1000, inactivity timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  level; 1 = machine in service
- cancel  in  1  active-low; falling edge = refund request
- Key_in  in  2  active-low coin keys; bit0 = 0.5 yuan (1 unit), bit1 = 1 yuan (2 units)
- sel  in  $clog2(N_PROD)  product select; sampled with buy
- buy  in  1  1-cycle purchase request pulse
- chg_rdy  in  1  dispenser ready
- chg_vld  out  1  change coin valid
- chg_coin  out  1  0 = 0.5-yuan coin, 1 = 1-yuan coin
- hold_ind  out  1  in service, collecting credit
- charge_ind  out  1  paying change
- drinktk_ind  out  1  1-cycle vend pulse
- drink_id  out  $clog2(N_PROD)  product vended; valid with drinktk_ind
- coin_val  out  2  last accepted coin (01 = 0.5, 10 = 1, 00 = none)
- coin_rej  out  1  1-cycle coin-reject pulse
- credit  out  PRICE_W  current credit
- charge_val  out  PRICE_W  change remaining to pay
- HEX  out  7*N_DIGITS  active-low segments, digit 0 at LSBs

Behaviour:
- Reset: state OFF; every output 0 except HEX = all 1s (blank).
- Edge detect: Key_in and cancel are registered every cycle. An event is the 1->0 transition, acted on in the cycle after the edge. Holding a key produces one event only.
- States: OFF, COLLECT, VEND, CHANGE.
- OFF: ignore keys and buy; hold_ind=0. start=1 -> COLLECT.
- COLLECT: hold_ind=1.
  - Coin event: credit += value if result <= CREDIT_MAX; else coin_rej=1 and credit is unchanged.
  - Both key bits falling in the same cycle: coin_rej=1, neither coin accepted.
  - buy with credit >= price[sel]: latch drink_id=sel and charge_val=credit-price, clear credit -> VEND.
  - buy with insufficient credit, or sel >= N_PROD: ignored, coin_rej=1.
  - Cancel event, or start=0: charge_val=credit, credit=0 -> CHANGE. If credit was 0, go directly to COLLECT, or to OFF when start=0.
  - Priority in the same cycle: cancel/start=0 > buy > coin.
- VEND: drinktk_ind=1 for exactly one cycle -> CHANGE.
- CHANGE: charge_ind=1; keys and buy ignored.
  - chg_vld=1 while charge_val>0; chg_coin=1 if charge_val>=2, else 0.
  - On chg_vld&&chg_rdy: charge_val -= (chg_coin?2:1).
  - chg_vld and chg_coin stay stable until accepted.
  - charge_val==0 -> COLLECT if start=1, else OFF.
- start dropping during VEND/CHANGE: finish paying change, then go to OFF.
- HEX: decimal value of credit (in COLLECT) or charge_val (in CHANGE), one digit per 7 bits, leading zeros shown, all segments off in OFF. Values above 10^N_DIGITS-1 show all digits as "-".
- rst asserted mid-operation: immediate return to reset values; pending credit is lost. This is documented behaviour.

Optional Feature:
- AUTOSELLER_TIMEOUT_EN defined: a counter in COLLECT with credit>0 counts cycles with no coin/buy/cancel event. Reaching TIMEOUT_CYC forces the cancel path (refund all credit). The counter clears on any event and on leaving COLLECT.
- Undefined: no counter logic is generated; credit is held indefinitely.

Decomposition:
- Package autoseller_pkg: state enum (OFF, COLLECT, VEND, CHANGE), coin unit constants (COIN_LO=1, COIN_HI=2), 7-seg active-low digit patterns 0-9, blank and dash constants.
- Sub-module seg7_dec: 4-bit BCD to 7-segment active-low decoder, instantiated N_DIGITS times.
- Binary-to-BCD conversion is combinational in the parent.

Test Plan:
- Reset then start=1; three 0.5 coin pulses -> credit=3, coin_val=01, HEX digits "03".
- credit=3, buy sel=0 (price 2) -> drinktk_ind one cycle, drink_id=0, then one chg_vld with chg_coin=0; chg_rdy=1 -> charge_val 0, back to COLLECT.
- Two 1-yuan coins (credit 4), cancel falling edge, chg_rdy held low 5 cycles then high -> chg_vld and chg_coin=1 stable while stalled; two coins paid; credit=0.
- credit=2, buy sel=3 (price 5) -> coin_rej pulse, no vend, credit stays 2; both key bits falling together -> coin_rej, credit unchanged.
- Coins up to 40, one more 0.5 coin -> coin_rej, credit=40; HEX shows "40".
- With AUTOSELLER_TIMEOUT_EN and TIMEOUT_CYC=10: insert 1 coin, wait 10 idle cycles -> CHANGE entered, one 0.5 coin refunded.
